// File: rtl/pov_spi_tx.sv
// SPI mode-0 initiator shipping the six POV view vectors MSB first in one ss_n frame.
// Optional POV_TX_SKIP_UNCHANGED_EN suppresses a frame whose vectors equal the last one sent.
module pov_spi_tx #(
  parameter int VEC_BITS = 24,
  parameter int CLK_DIV  = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                i_start,
  input  logic [VEC_BITS-1:0] i_playerX,
  input  logic [VEC_BITS-1:0] i_playerY,
  input  logic [VEC_BITS-1:0] i_facingX,
  input  logic [VEC_BITS-1:0] i_facingY,
  input  logic [VEC_BITS-1:0] i_vplaneX,
  input  logic [VEC_BITS-1:0] i_vplaneY,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_sclk,
  output logic                o_mosi,
  output logic                o_ss_n
);

  localparam int FRAME_BITS = 6 * VEC_BITS;
  localparam int CNT_W      = $clog2(FRAME_BITS);
  localparam int DIV_W      = $clog2(CLK_DIV);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT_HI,
    SHIFT_LO,
    HOLD,
    GAP,
    SKIP
  } state_t;

  state_t                  state;
  logic [FRAME_BITS-1:0]   shreg;
  logic [CNT_W-1:0]        bit_cnt;
  logic [DIV_W-1:0]        div;
  logic                    div_last;
  logic                    skip_hit;
  logic [FRAME_BITS-1:0]   frame_in;

  assign frame_in = {i_playerX, i_playerY, i_facingX, i_facingY, i_vplaneX, i_vplaneY};
  assign div_last = (div == DIV_W'(CLK_DIV - 1));

`ifdef POV_TX_SKIP_UNCHANGED_EN
  logic [FRAME_BITS-1:0] last_sent;

  assign skip_hit = (frame_in == last_sent);

  // Captured at acceptance: the only way to abort a frame is reset, which clears this anyway.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_sent <= '0;
    end else if (state == IDLE && i_start && !skip_hit) begin
      last_sent <= frame_in;
    end
  end
`else
  assign skip_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      div     <= '0;
      o_ss_n  <= 1'b1;
      o_sclk  <= 1'b0;
      o_mosi  <= 1'b0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
    end else begin
      // NOTE: non-blocking defaults here are overridden by later assignments in the case arms,
      // which is how o_done becomes a single-cycle pulse without an extra clear state.
      o_done <= 1'b0;
      div    <= div_last ? '0 : div + 1'b1;

      case (state)
        IDLE: begin
          div <= '0;
          if (i_start && skip_hit) begin
            o_busy <= 1'b1;
            state  <= SKIP;
          end else if (i_start) begin
            shreg   <= frame_in;
            bit_cnt <= CNT_W'(FRAME_BITS - 1);
            o_ss_n  <= 1'b0;
            o_mosi  <= frame_in[FRAME_BITS-1];
            o_busy  <= 1'b1;
            state   <= SETUP;
          end
        end

        SETUP: begin
          if (div_last) begin
            o_sclk <= 1'b1;
            state  <= SHIFT_HI;
          end
        end

        SHIFT_HI: begin
          if (div_last) begin
            o_sclk <= 1'b0;
            if (bit_cnt == '0) begin
              state <= HOLD;
            end else begin
              // Data changes on the falling edge so it is settled for a full low phase.
              shreg   <= shreg << 1;
              bit_cnt <= bit_cnt - 1'b1;
              o_mosi  <= shreg[FRAME_BITS-2];
              state   <= SHIFT_LO;
            end
          end
        end

        SHIFT_LO: begin
          if (div_last) begin
            o_sclk <= 1'b1;
            state  <= SHIFT_HI;
          end
        end

        HOLD: begin
          if (div_last) begin
            o_ss_n <= 1'b1;
            o_mosi <= 1'b0;
            o_done <= 1'b1;
            state  <= GAP;
          end
        end

        GAP: begin
          if (div_last) begin
            o_busy <= 1'b0;
            state  <= IDLE;
          end
        end

        SKIP: begin
          o_busy <= 1'b0;
          o_done <= 1'b1;
          state  <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pov_spi_tx.sv
// Directed bench for pov_spi_tx: two instances (CLK_DIV=2 and CLK_DIV=5) share the vector inputs.
// A behavioural receiver samples outputs on the falling clk edge and captures bits on sclk rise.
module tb_pov_spi_tx;

  localparam int VB = 24;
  localparam int FB = 6 * VB;

  localparam logic [FB-1:0] FRAME_A = {24'h123456, 24'hABCDEF, 24'h000001,
                                       24'h800000, 24'hFFFFFF, 24'h5A5A5A};
  localparam logic [FB-1:0] FRAME_B = {24'hC0FFEE, 24'h000000, 24'h7FFFFF,
                                       24'h010203, 24'hFEDCBA, 24'h0F0F0F};
  localparam logic [FB-1:0] FRAME_C = {24'h111111, 24'h222222, 24'h333333,
                                       24'h444444, 24'h555555, 24'h666666};
  localparam logic [FB-1:0] FRAME_D = {24'hA5A5A5, 24'h3C3C3C, 24'h000100,
                                       24'hDEAD00, 24'h00BEEF, 24'h999999};
  localparam logic [FB-1:0] FRAME_E = {24'h876543, 24'h0000FF, 24'hF00000,
                                       24'h13579B, 24'h2468AC, 24'hFFFFFE};
  localparam logic [FB-1:0] FRAME_F = {24'h400000, 24'h000002, 24'h0ABCDE,
                                       24'hEDCBA0, 24'h777777, 24'h888888};
  localparam logic [FB-1:0] FRAME_G = {24'h010101, 24'h020202, 24'h030303,
                                       24'h040404, 24'h050505, 24'h060606};
  localparam logic [FB-1:0] FRAME_H = {24'hFEFEFE, 24'h000003, 24'hC3C3C3,
                                       24'h5555AA, 24'h8000FF, 24'h0000A0};

  logic          clk;
  logic          reset_n;
  logic [1:0]    start;
  logic [VB-1:0] px, py, fx, fy, vx, vy;
  logic [1:0]    busy, done, sclk, mosi, ss_n;

  int compared;
  int mismatched;

  pov_spi_tx #(.VEC_BITS(VB), .CLK_DIV(2)) dut (
    .clk(clk), .reset_n(reset_n), .i_start(start[0]),
    .i_playerX(px), .i_playerY(py), .i_facingX(fx), .i_facingY(fy),
    .i_vplaneX(vx), .i_vplaneY(vy),
    .o_busy(busy[0]), .o_done(done[0]), .o_sclk(sclk[0]), .o_mosi(mosi[0]), .o_ss_n(ss_n[0])
  );

  pov_spi_tx #(.VEC_BITS(VB), .CLK_DIV(5)) dut5 (
    .clk(clk), .reset_n(reset_n), .i_start(start[1]),
    .i_playerX(px), .i_playerY(py), .i_facingX(fx), .i_facingY(fy),
    .i_vplaneX(vx), .i_vplaneY(vy),
    .o_busy(busy[1]), .o_done(done[1]), .o_sclk(sclk[1]), .o_mosi(mosi[1]), .o_ss_n(ss_n[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int div_of(input int d);
    return (d == 0) ? 2 : 5;
  endfunction

  task automatic set_vec(input logic [FB-1:0] f);
    px = f[143:120];
    py = f[119:96];
    fx = f[95:72];
    fy = f[71:48];
    vx = f[47:24];
    vy = f[23:0];
  endtask

  // Starts one frame on instance d and observes it until busy drops.
  task automatic run_frame(input int d, input logic [FB-1:0] frame,
                           input int pulse_a, input int pulse_b, input bit zero_after,
                           output logic [FB-1:0] got, output int nbits, output int low_cyc,
                           output int done_cnt, output int falls, output int viol,
                           output bit timeout);
    logic prev_ss, prev_sclk, prev_mosi;
    int   stable, hi_run;
    got = '0; nbits = 0; low_cyc = 0; done_cnt = 0; falls = 0; viol = 0; timeout = 1'b1;
    stable = 100; hi_run = 0;
    @(negedge clk);
    set_vec(frame);
    start[d]  = 1'b1;
    prev_ss   = ss_n[d];
    prev_sclk = sclk[d];
    prev_mosi = mosi[d];
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      start[d] = (cyc == pulse_a) || (cyc == pulse_b);
      if (cyc == 0 && zero_after) set_vec('0);
      if (!ss_n[d]) low_cyc++;
      if (done[d]) done_cnt++;
      if (prev_ss && !ss_n[d]) falls++;
      if (sclk[d] && !prev_sclk) begin
        if (mosi[d] !== prev_mosi || stable < div_of(d)) viol++;
        got = {got[FB-2:0], mosi[d]};
        nbits++;
      end
      if (sclk[d] && prev_sclk && mosi[d] !== prev_mosi) viol++;
      if (!sclk[d] && prev_sclk && hi_run != div_of(d)) viol++;
      hi_run = sclk[d] ? hi_run + 1 : 0;
      stable = (mosi[d] === prev_mosi) ? stable + 1 : 1;
      prev_ss   = ss_n[d];
      prev_sclk = sclk[d];
      prev_mosi = mosi[d];
      if (!busy[d]) begin
        timeout = 1'b0;
        break;
      end
    end
    start[d] = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start   = 2'b00;
    set_vec('0);
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      compared++;
      if ({ss_n[d], sclk[d], mosi[d], busy[d], done[d]} !== 5'b10000) begin
        mismatched++;
        $display("FAIL reset_state[%0d]: ss_n/sclk/mosi/busy/done got %b want 10000", d,
                 {ss_n[d], sclk[d], mosi[d], busy[d], done[d]});
      end
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_frame(input string name, input int d, input logic [FB-1:0] exp,
                             input int exp_low, input int pulse_a, input int pulse_b,
                             input bit zero_after);
    logic [FB-1:0] got;
    int nbits, low_cyc, done_cnt, falls, viol;
    bit timeout;
    run_frame(d, exp, pulse_a, pulse_b, zero_after, got, nbits, low_cyc, done_cnt, falls, viol,
              timeout);
    compared++;
    if (timeout !== 1'b0) begin
      mismatched++; $display("FAIL %s_timeout: busy never fell", name);
    end
    compared++;
    if (nbits !== FB || got !== exp) begin
      mismatched++; $display("FAIL %s_data: %0d bits %h want %0d bits %h", name, nbits, got, FB, exp);
    end
    compared++;
    if (low_cyc !== exp_low) begin
      mismatched++; $display("FAIL %s_ss_low: got %0d cycles want %0d", name, low_cyc, exp_low);
    end
    compared++;
    if (done_cnt !== 1 || falls !== 1) begin
      mismatched++;
      $display("FAIL %s_pulses: done %0d ss_n falls %0d want 1 and 1", name, done_cnt, falls);
    end
    compared++;
    if (viol !== 0) begin
      mismatched++; $display("FAIL %s_setup_hold: %0d violations want 0", name, viol);
    end
  endtask

  task automatic test_single_frame();
    check_frame("single", 0, FRAME_A, 578, -1, -1, 1'b0);
  endtask

  task automatic test_setup_hold_div5();
    check_frame("div5", 1, FRAME_D, 1445, -1, -1, 1'b0);
  endtask

  task automatic test_busy_reject();
    int active;
    check_frame("reject", 0, FRAME_C, 578, 10, 300, 1'b0);
    active = 0;
    repeat (8) begin
      @(negedge clk);
      if (!ss_n[0] || busy[0]) active++;
    end
    compared++;
    if (active !== 0) begin
      mismatched++; $display("FAIL reject_not_queued: %0d active cycles want 0", active);
    end
  endtask

  task automatic test_capture();
    check_frame("capture", 0, FRAME_E, 578, -1, -1, 1'b1);
  endtask

  task automatic test_back_to_back();
    int falls, gap_hi, busy_lo, nb;
    bit prev_ss, prev_sclk, to;
    logic [FB-1:0] got;
    falls = 0; gap_hi = 0; busy_lo = 0; nb = 0; to = 1'b1; got = '0;
    @(negedge clk);
    set_vec(FRAME_G);
    start[0]  = 1'b1;
    prev_ss   = ss_n[0];
    prev_sclk = sclk[0];
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      if (prev_ss && !ss_n[0]) begin
        falls++;
        if (falls == 1) set_vec(FRAME_H);
        else start[0] = 1'b0;
      end
      if (falls == 1 && ss_n[0]) gap_hi++;
      if (falls == 1 && !busy[0]) busy_lo++;
      if (falls == 2 && sclk[0] && !prev_sclk) begin
        got = {got[FB-2:0], mosi[0]};
        nb++;
      end
      prev_ss   = ss_n[0];
      prev_sclk = sclk[0];
      if (falls == 2 && !busy[0]) begin
        to = 1'b0;
        break;
      end
    end
    start[0] = 1'b0;
    compared++;
    if (to !== 1'b0 || falls !== 2) begin
      mismatched++; $display("FAIL b2b_frames: falls %0d timeout %0d want 2 and 0", falls, to);
    end
    compared++;
    if (busy_lo !== 1) begin
      mismatched++; $display("FAIL b2b_busy_low: got %0d cycles want 1", busy_lo);
    end
    compared++;
    if (gap_hi !== 3) begin
      mismatched++; $display("FAIL b2b_gap: ss_n high %0d cycles want 3", gap_hi);
    end
    compared++;
    if (nb !== FB || got !== FRAME_H) begin
      mismatched++; $display("FAIL b2b_second_data: %0d bits %h want %h", nb, got, FRAME_H);
    end
  endtask

  task automatic test_reset_abort();
    int rises, quiet_bad;
    bit prev_sclk, reached;
    rises = 0; reached = 1'b0; quiet_bad = 0;
    @(negedge clk);
    set_vec(FRAME_B);
    start[0]  = 1'b1;
    prev_sclk = sclk[0];
    for (int cyc = 0; cyc < 1000; cyc++) begin
      @(negedge clk);
      start[0] = 1'b0;
      if (sclk[0] && !prev_sclk) rises++;
      prev_sclk = sclk[0];
      if (rises == 70) begin
        reached = 1'b1;
        break;
      end
    end
    compared++;
    if (reached !== 1'b1 || sclk[0] !== 1'b1 || ss_n[0] !== 1'b0) begin
      mismatched++;
      $display("FAIL abort_mid_shift: reached %0d sclk %b ss_n %b want 1 1 0", reached, sclk[0],
               ss_n[0]);
    end
    reset_n = 1'b0;
    #1;
    compared++;
    if ({ss_n[0], sclk[0], mosi[0], busy[0], done[0]} !== 5'b10000) begin
      mismatched++;
      $display("FAIL abort_outputs: ss_n/sclk/mosi/busy/done got %b want 10000",
               {ss_n[0], sclk[0], mosi[0], busy[0], done[0]});
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (done[0] || !ss_n[0] || busy[0]) quiet_bad++;
    end
    compared++;
    if (quiet_bad !== 0) begin
      mismatched++; $display("FAIL abort_quiet: %0d active cycles want 0", quiet_bad);
    end
    check_frame("after_abort", 0, FRAME_B, 578, -1, -1, 1'b0);
  endtask

  task automatic test_skip_unchanged();
    logic [FB-1:0] f2;
    check_frame("skip_first", 0, FRAME_F, 578, -1, -1, 1'b0);
`ifdef POV_TX_SKIP_UNCHANGED_EN
    @(negedge clk);
    set_vec(FRAME_F);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    compared++;
    if ({ss_n[0], busy[0], done[0]} !== 3'b110) begin
      mismatched++; $display("FAIL skip_cycle1: ss_n/busy/done got %b want 110",
                             {ss_n[0], busy[0], done[0]});
    end
    @(negedge clk);
    compared++;
    if ({ss_n[0], busy[0], done[0]} !== 3'b101) begin
      mismatched++; $display("FAIL skip_cycle2: ss_n/busy/done got %b want 101",
                             {ss_n[0], busy[0], done[0]});
    end
    @(negedge clk);
    compared++;
    if ({ss_n[0], busy[0], done[0]} !== 3'b100) begin
      mismatched++; $display("FAIL skip_cycle3: ss_n/busy/done got %b want 100",
                             {ss_n[0], busy[0], done[0]});
    end
`else
    check_frame("repeat_same", 0, FRAME_F, 578, -1, -1, 1'b0);
`endif
    f2 = FRAME_F;
    f2[143:120] = FRAME_F[143:120] + 24'd1;
    check_frame("skip_changed", 0, f2, 578, -1, -1, 1'b0);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    test_reset();
    test_single_frame();
    test_setup_hold_div5();
    test_busy_reject();
    test_capture();
    test_back_to_back();
    test_reset_abort();
    test_skip_unchanged();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pov_spi_tx.md
Name: pov_spi_tx

Overview:
- SPI initiator that serialises the six POV view vectors (playerX, playerY, facingX, facingY, vplaneX, vplaneY) onto the 3-wire SPI link (sclk, mosi, ss_n) consumed by the renderer's POV receiver.
- Used in the FPGA host/test harness and the companion controller: one full vector set is shipped per transaction, and the renderer applies it at its next visible-frame end.
- SPI mode 0. Bits go MSB first; the vectors go in the order listed above.

Parameters:
- VEC_BITS, 24: width of each fixed-point vector; frame length is 6*VEC_BITS bits.
- CLK_DIV, 2: clk cycles per SCLK half-period; legal range is >=2 so the receiver's synchroniser can track SCLK.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous, active-low reset.
- i_start  input  1  transmit request; sampled on a clk rising edge.
- i_playerX, i_playerY, i_facingX, i_facingY, i_vplaneX, i_vplaneY  input  VEC_BITS each  vector values; captured when i_start is accepted.
- o_busy  output  1  high from start acceptance until the end of the inter-frame gap.
- o_done  output  1  one-cycle pulse at the end of each transaction.
- o_sclk  output  1  SPI clock; idles low.
- o_mosi  output  1  SPI data.
- o_ss_n  output  1  active-low slave select; idles high.

Behaviour:
- Reset (async assert, synchronous deassert handled upstream): state=IDLE. o_ss_n=1, o_sclk=0, o_mosi=0, o_busy=0, o_done=0; the bit counter and the divider clear.
- Reset asserted mid-frame aborts the frame immediately, with no o_done pulse. The receiver sees ss_n rise, which discards the partial frame.
- FSM states: IDLE, SETUP, SHIFT_HI, SHIFT_LO, HOLD, GAP. A divider counts 0..CLK_DIV-1 within each phase.
- IDLE: on i_start=1 at an edge:
  - Load a 6*VEC_BITS shift register as {playerX,playerY,facingX,facingY,vplaneX,vplaneY}.
  - Set bit counter = 6*VEC_BITS-1.
  - Registered outputs from that edge: o_ss_n=0, o_mosi=MSB, o_busy=1. Go to SETUP.
- SETUP: CLK_DIV cycles with o_sclk=0, then go to SHIFT_HI.
- SHIFT_HI: o_sclk=1 for CLK_DIV cycles; the receiver samples here. On exit:
  - If bit counter == 0, go to HOLD.
  - Otherwise shift left, decrement the counter, put the new MSB on o_mosi and go to SHIFT_LO. o_sclk falls on the same edge that o_mosi changes.
- SHIFT_LO: o_sclk=0 for CLK_DIV cycles, then go to SHIFT_HI.
- HOLD: o_sclk=0, o_mosi unchanged, for CLK_DIV cycles. On exit: o_ss_n=1, o_mosi=0, o_done=1 for exactly one cycle, go to GAP.
- GAP: o_ss_n=1 for CLK_DIV cycles, then o_busy=0 and go to IDLE.
- Timing:
  - o_ss_n low duration = (2*6*VEC_BITS+1)*CLK_DIV cycles; with the defaults that is 578.
  - Start-to-done = that duration plus 1 cycle.
  - Back-to-back i_start held high: the next frame starts on the first edge after o_busy falls.
- i_start while o_busy=1 is ignored; it is not queued.
- Input vectors changing during a frame have no effect, because only the captured copy is sent.
- All outputs are registered, with no combinational path from inputs to SPI pins.

Optional Feature:
- Macro: POV_TX_SKIP_UNCHANGED_EN.
- Defined:
  - A 6*VEC_BITS "last sent" register holds the last completed frame and is cleared to 0 on reset.
  - If i_start is accepted while the inputs equal that register, there is no SPI activity: o_busy=1 for one cycle, o_done pulses on the next cycle, and the block returns to IDLE.
  - An aborted frame does not update the register.
- Undefined: every accepted i_start sends a full frame, and the register does not exist.

Test Plan:
- Reset behaviour: assert reset_n=0 mid-SHIFT at bit 70 -> o_ss_n=1, o_sclk=0, o_mosi=0 within the same cycle and no o_done. After release, a fresh i_start sends a complete frame.
- Single frame, defaults, vectors 24'h123456, 24'hABCDEF, 24'h000001, 24'h800000, 24'hFFFFFF, 24'h5A5A5A:
  - The bench receiver captures 144 bits on o_sclk rising edges and they match the concatenation.
  - o_ss_n is low for exactly 578 cycles and o_done pulses once.
- Setup/hold: o_mosi is stable for >=CLK_DIV cycles before and CLK_DIV cycles during each o_sclk high phase, and never changes while o_sclk=1. Repeat with CLK_DIV=5 (o_ss_n low 1445 cycles).
- Busy rejection: pulse i_start at cycles 10 and 300 of a frame -> only one frame is sent. With i_start held high, a second frame begins 1 cycle after o_busy falls, with o_ss_n high for >=CLK_DIV cycles between frames.
- Capture: change all vectors to 0 one cycle after start -> the transmitted data equals the pre-change values.
- POV_TX_SKIP_UNCHANGED_EN:
  - Send vectors V, then start again with V: no o_ss_n activity, and o_done arrives 2 cycles after i_start.
  - Change playerX by 1 LSB, then start: a full 144-bit frame is sent.
